// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bus for the MIPS execute stage.
// The ID side drives the in_* fields and the MEM side consumes the *_out fields.
interface ex_stage_if;
    logic        in_RegDst;
    logic        in_RegWrite;
    logic        in_ALUSrc;
    logic        in_MemWrite;
    logic        in_MemRead;
    logic        in_MemToReg;
    logic [2:0]  in_ALUOp;
    logic [4:0]  in_instr_bits_15_11;
    logic [4:0]  in_instr_bits_20_16;
    logic [31:0] in_extended_bits;
    logic [31:0] in_read_data1;
    logic [31:0] in_read_data2;
    logic [31:0] in_new_pc_value;
    logic [1:0]  in_load_mode;

    logic        zero_out;
    logic        RegWrite_out;
    logic        MemWrite_out;
    logic        MemRead_out;
    logic        MemToReg_out;
    logic [1:0]  load_mode_out;
    logic [4:0]  writebackDestination_out;
    logic [31:0] aluResult_out;
    logic [31:0] rt_out;
    logic [31:0] pc_out;

    modport master (
        output in_RegDst, in_RegWrite, in_ALUSrc, in_MemWrite, in_MemRead, in_MemToReg,
               in_ALUOp, in_instr_bits_15_11, in_instr_bits_20_16, in_extended_bits,
               in_read_data1, in_read_data2, in_new_pc_value, in_load_mode,
        input  zero_out, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out,
               load_mode_out, writebackDestination_out, aluResult_out, rt_out, pc_out
    );

    modport slave (
        input  in_RegDst, in_RegWrite, in_ALUSrc, in_MemWrite, in_MemRead, in_MemToReg,
               in_ALUOp, in_instr_bits_15_11, in_instr_bits_20_16, in_extended_bits,
               in_read_data1, in_read_data2, in_new_pc_value, in_load_mode,
        output zero_out, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out,
               load_mode_out, writebackDestination_out, aluResult_out, rt_out, pc_out
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand select, ALU, writeback-register select and branch target,
// all captured every cycle in the EX/MEM pipeline register.
module ex_stage (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [DW-1:0] alu_result;

    logic          zero_d,      zero_q;
    logic          reg_write_d, reg_write_q;
    logic          mem_write_d, mem_write_q;
    logic          mem_read_d,  mem_read_q;
    logic          mem_to_reg_d, mem_to_reg_q;
    logic [1:0]    load_mode_d, load_mode_q;
    logic [RW-1:0] wb_dest_d,   wb_dest_q;
    logic [DW-1:0] alu_res_d,   alu_res_q;
    logic [DW-1:0] rt_d,        rt_q;
    logic [DW-1:0] pc_d,        pc_q;

    // ALU: ALUOp class decode, R-type sub-decode on funct; unknown funct yields 0
    always_comb begin
        op_a       = bus.in_read_data1;
        op_b       = bus.in_ALUSrc ? bus.in_extended_bits : bus.in_read_data2;
        shamt      = bus.in_extended_bits[10:6];
        funct      = bus.in_extended_bits[5:0];
        alu_result = '0;
        unique case (bus.in_ALUOp)
            3'b000: alu_result = op_a - op_b;
            3'b001: alu_result = op_a & op_b;
            3'b011: alu_result = op_a | op_b;
            3'b100: alu_result = op_a + op_b;
            3'b101: alu_result = {31'b0, ($signed(op_a) < $signed(op_b))};
            3'b110: alu_result = op_b << 16;
            3'b111: alu_result = op_a ^ op_b;
            3'b010: begin
                case (funct)
                    6'b100000: alu_result = op_a + op_b;
                    6'b100010: alu_result = op_a - op_b;
                    6'b100100: alu_result = op_a & op_b;
                    6'b100101: alu_result = op_a | op_b;
                    6'b100110: alu_result = op_a ^ op_b;
                    6'b100111: alu_result = ~(op_a | op_b);
                    6'b101010: alu_result = {31'b0, ($signed(op_a) < $signed(op_b))};
                    6'b101011: alu_result = {31'b0, (op_a < op_b)};
                    // shifts always act on rt, independent of ALUSrc
                    6'b000000: alu_result = bus.in_read_data2 << shamt;
                    6'b000010: alu_result = bus.in_read_data2 >> shamt;
                    6'b000011: alu_result = DW'($unsigned($signed(bus.in_read_data2) >>> shamt));
                    default:   alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    // EX/MEM register next values
    always_comb begin
        alu_res_d    = alu_result;
        zero_d       = (alu_result == '0);
        reg_write_d  = bus.in_RegWrite;
        mem_write_d  = bus.in_MemWrite;
        mem_read_d   = bus.in_MemRead;
        mem_to_reg_d = bus.in_MemToReg;
        load_mode_d  = bus.in_load_mode;
        wb_dest_d    = bus.in_RegDst ? bus.in_instr_bits_15_11 : bus.in_instr_bits_20_16;
        rt_d         = bus.in_read_data2;
        pc_d         = bus.in_new_pc_value + {bus.in_extended_bits[DW-3:0], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            load_mode_q  <= '0;
            wb_dest_q    <= '0;
            alu_res_q    <= '0;
            rt_q         <= '0;
            pc_q         <= '0;
        end else begin
            zero_q       <= zero_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            load_mode_q  <= load_mode_d;
            wb_dest_q    <= wb_dest_d;
            alu_res_q    <= alu_res_d;
            rt_q         <= rt_d;
            pc_q         <= pc_d;
        end
    end

    assign bus.zero_out                 = zero_q;
    assign bus.RegWrite_out             = reg_write_q;
    assign bus.MemWrite_out             = mem_write_q;
    assign bus.MemRead_out              = mem_read_q;
    assign bus.MemToReg_out             = mem_to_reg_q;
    assign bus.load_mode_out            = load_mode_q;
    assign bus.writebackDestination_out = wb_dest_q;
    assign bus.aluResult_out            = alu_res_q;
    assign bus.rt_out                   = rt_q;
    assign bus.pc_out                   = pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: stimulus pushes expected EX/MEM contents to a queue,
// popped and compared one cycle later after the capturing edge.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ex_stage_if bus ();

    ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        regdst, regwrite, alusrc, memwrite, memread, memtoreg;
        logic [2:0]  aluop;
        logic [4:0]  rd, rt;
        logic [31:0] ext, a, b, pc;
        logic [1:0]  lm;
    } stim_t;

    typedef struct {
        logic        zero, rw, mw, mr, m2r;
        logic [1:0]  lm;
        logic [4:0]  wb;
        logic [31:0] alu, rt, pc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    exp_t zero_exp;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic slt_s(logic [31:0] x, logic [31:0] y);
        return (x ^ 32'h8000_0000) < (y ^ 32'h8000_0000);
    endfunction

    function automatic exp_t model(stim_t s);
        exp_t        e;
        logic [31:0] bb;
        logic [31:0] r;
        logic [4:0]  sh;
        logic [5:0]  fn;
        bb = s.alusrc ? s.ext : s.b;
        sh = s.ext[10:6];
        fn = s.ext[5:0];
        r  = 32'd0;
        case (s.aluop)
            3'd0: r = s.a + (~bb + 32'd1);
            3'd1: r = s.a & bb;
            3'd3: r = s.a | bb;
            3'd4: r = s.a + bb;
            3'd5: r = slt_s(s.a, bb) ? 32'd1 : 32'd0;
            3'd6: r = {bb[15:0], 16'h0000};
            3'd7: r = s.a ^ bb;
            default: begin
                case (fn)
                    6'h20: r = s.a + bb;
                    6'h22: r = s.a - bb;
                    6'h24: r = s.a & bb;
                    6'h25: r = s.a | bb;
                    6'h26: r = s.a ^ bb;
                    6'h27: r = ~s.a & ~bb;
                    6'h2A: r = slt_s(s.a, bb) ? 32'd1 : 32'd0;
                    6'h2B: r = (s.a < bb) ? 32'd1 : 32'd0;
                    6'h00: r = s.b * (32'd1 << sh);
                    6'h02: r = s.b >> sh;
                    6'h03: r = (s.b >> sh) | (s.b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                    default: r = 32'd0;
                endcase
            end
        endcase
        e.alu  = r;
        e.zero = (r == 32'd0);
        e.rw   = s.regwrite;
        e.mw   = s.memwrite;
        e.mr   = s.memread;
        e.m2r  = s.memtoreg;
        e.lm   = s.lm;
        e.wb   = s.regdst ? s.rd : s.rt;
        e.rt   = s.b;
        e.pc   = s.pc + s.ext * 32'd4;
        return e;
    endfunction

    function automatic stim_t mk(logic [2:0] op, logic src, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] ext);
        stim_t s;
        s = '{regdst: 1'b0, regwrite: 1'b1, alusrc: src, memwrite: 1'b0, memread: 1'b0,
              memtoreg: 1'b0, aluop: op, rd: 5'd0, rt: 5'd0, ext: ext, a: a, b: b,
              pc: 32'd0, lm: 2'd0};
        return s;
    endfunction

    task automatic apply(stim_t s);
        bus.in_RegDst           = s.regdst;
        bus.in_RegWrite         = s.regwrite;
        bus.in_ALUSrc           = s.alusrc;
        bus.in_MemWrite         = s.memwrite;
        bus.in_MemRead          = s.memread;
        bus.in_MemToReg         = s.memtoreg;
        bus.in_ALUOp            = s.aluop;
        bus.in_instr_bits_15_11 = s.rd;
        bus.in_instr_bits_20_16 = s.rt;
        bus.in_extended_bits    = s.ext;
        bus.in_read_data1       = s.a;
        bus.in_read_data2       = s.b;
        bus.in_new_pc_value     = s.pc;
        bus.in_load_mode        = s.lm;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag, exp_t e);
        chk({tag, ".alu"},  bus.aluResult_out, e.alu);
        chk({tag, ".zero"}, 32'(bus.zero_out), 32'(e.zero));
        chk({tag, ".rw"},   32'(bus.RegWrite_out), 32'(e.rw));
        chk({tag, ".mw"},   32'(bus.MemWrite_out), 32'(e.mw));
        chk({tag, ".mr"},   32'(bus.MemRead_out), 32'(e.mr));
        chk({tag, ".m2r"},  32'(bus.MemToReg_out), 32'(e.m2r));
        chk({tag, ".lm"},   32'(bus.load_mode_out), 32'(e.lm));
        chk({tag, ".wb"},   32'(bus.writebackDestination_out), 32'(e.wb));
        chk({tag, ".rt"},   bus.rt_out, e.rt);
        chk({tag, ".pc"},   bus.pc_out, e.pc);
    endtask

    // Drive at negedge, capture on the next posedge, compare 1 time unit later.
    task automatic step(string tag, stim_t s);
        @(negedge clk);
        apply(s);
        sb.push_back(model(s));
        @(posedge clk);
        #1;
        last_exp = sb.pop_front();
        check_all(tag, last_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        logic [5:0] functs [10];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h02, 6'h03, 6'h3F};
        zero_exp = '{zero: 1'b0, rw: 1'b0, mw: 1'b0, mr: 1'b0, m2r: 1'b0, lm: 2'd0, wb: 5'd0,
                     alu: 32'd0, rt: 32'd0, pc: 32'd0};

        // reset state with nonzero inputs, across several edges
        s = mk(3'd4, 1'b0, 32'd5, 32'd6, 32'd3);
        s.memread = 1'b1; s.lm = 2'd3; s.rt = 5'd7; s.pc = 32'd40;
        apply(s);
        #1 check_all("reset_init", zero_exp);
        repeat (2) @(posedge clk);
        #1 check_all("reset_hold", zero_exp);

        // TP: add, register operand
        s = mk(3'd4, 1'b0, 32'd7, 32'd7, 32'd32);
        s.memread = 1'b1; s.lm = 2'd2;
        @(negedge clk);
        rst_n = 1'b1;
        step("add_reg", s);
        chk("add_reg.c14", bus.aluResult_out, 32'd14);
        chk("add_reg.c_rt", bus.rt_out, 32'd7);

        // TP: add immediate, store, branch target
        s = mk(3'd4, 1'b1, 32'd7, 32'd8, 32'd32);
        s.memwrite = 1'b1; s.pc = 32'd100;
        step("add_imm", s);
        chk("add_imm.c39", bus.aluResult_out, 32'd39);
        chk("add_imm.c228", bus.pc_out, 32'd228);
        chk("add_imm.c_rt", bus.rt_out, 32'd8);

        // TP: subtract to zero, then to -1
        step("sub_zero", mk(3'd0, 1'b0, 32'd7, 32'd7, 32'd0));
        chk("sub_zero.cz", 32'(bus.zero_out), 32'd1);
        step("sub_neg", mk(3'd0, 1'b0, 32'd7, 32'd8, 32'd0));
        chk("sub_neg.cff", bus.aluResult_out, 32'hFFFF_FFFF);

        // TP: R-type slt and sll, rd destination
        s = mk(3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_002A);
        s.regdst = 1'b1; s.rd = 5'd9; s.rt = 5'd4;
        step("slt", s);
        chk("slt.c1", bus.aluResult_out, 32'd1);
        chk("slt.cwb", 32'(bus.writebackDestination_out), 32'd9);
        s.b = 32'd3; s.ext = 32'h0000_0100;
        step("sll", s);
        chk("sll.c48", bus.aluResult_out, 32'd48);
        chk("sll.cwb", 32'(bus.writebackDestination_out), 32'd9);

        // remaining funct codes incl. unknown, random operands, shamt 7
        foreach (functs[i]) begin
            s = mk(3'd2, 1'b0, $urandom, 32'h8000_0000 | $urandom, {21'd0, 5'd7, functs[i]});
            s.lm = 2'(i);
            step($sformatf("funct_%0h", functs[i]), s);
        end
        chk("unknown_funct.cz", 32'(bus.zero_out), 32'd1);

        // other ALUOp classes and immediates
        step("and",  mk(3'd1, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0));
        step("or",   mk(3'd3, 1'b1, 32'h1200_0000, 32'd0, 32'h0000_0034));
        step("slti", mk(3'd5, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFE));
        step("lui",  mk(3'd6, 1'b1, 32'd0, 32'd0, 32'h0000_ABCD));
        chk("lui.c", bus.aluResult_out, 32'hABCD_0000);
        step("xor",  mk(3'd7, 1'b0, 32'hAAAA_5555, 32'hAAAA_5555, 32'd0));
        step("wrap", mk(3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0));
        chk("wrap.cz", 32'(bus.zero_out), 32'd1);
        s = mk(3'd4, 1'b0, 32'd1, 32'd2, 32'hFFFF_FFFD);
        s.pc = 32'd100;
        step("back_branch", s);
        chk("back_branch.c88", bus.pc_out, 32'd88);

        // MemRead+MemWrite together forwarded as-is; output holds between edges
        s = mk(3'd4, 1'b0, 32'd1, 32'd1, 32'd0);
        s.memread = 1'b1; s.memwrite = 1'b1; s.memtoreg = 1'b1; s.rt = 5'd4; s.rd = 5'd17;
        step("hold_base", s);
        chk("hold_base.cwb4", 32'(bus.writebackDestination_out), 32'd4);
        chk("hold_base.cm2r", 32'(bus.MemToReg_out), 32'd1);
        apply(mk(3'd0, 1'b1, 32'd9, 32'd3, 32'd1));
        #2 check_all("hold_mid", last_exp);

        // reset asserted mid-cycle, then released mid-stream
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("reset_async", zero_exp);
        @(posedge clk);
        #1 check_all("reset_edge", zero_exp);
        s = mk(3'd7, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'd2);
        s.regdst = 1'b1; s.rd = 5'd31; s.lm = 2'd1; s.pc = 32'd8;
        @(negedge clk);
        apply(s);
        rst_n = 1'b1;
        sb.push_back(model(s));
        @(posedge clk);
        #1;
        last_exp = sb.pop_front();
        check_all("reset_release", last_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
